au_acc_seq: RTL and testbench
=============================

# au_acc_seq

Accumulator sequencer that sits directly upstream and downstream of the 8-bit arithmetic unit (`au`). It accepts operation commands over a valid/ready channel and drives the AU's `x`, `y`, `s0`, `s1` and `cin` inputs. It writes the AU result `f`/`cout` back into an 8-bit accumulator once per cycle, for a programmable repeat count. When the command completes, it returns the accumulator and C/Z/N/V flags over a valid/ready response channel.

## Interface
- `CNT_W`, 4, width of the repeat-count field. The operation is applied `cmd_rep+1` times.
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  3  AU operation: 0 xfer acc, 1 acc+1, 2 acc+y, 3 acc+y+1, 4 acc−y, 5 acc−y−1, 6 acc−1, 7 xfer y (load)
- `cmd_data`  in  8  y operand
- `cmd_rep`  in  CNT_W  repeat count minus one
- `au_x`  out  8  to AU `x`
- `au_y`  out  8  to AU `y`
- `au_s1`, `au_s0`, `au_cin`  out  1 each  to AU selects
- `au_f`  in  8  AU result
- `au_cout`  in  1  AU carry-out
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_acc`  out  8  final accumulator value
- `rsp_c`, `rsp_z`, `rsp_n`, `rsp_v`  out  1 each  carry, zero, negative, signed-overflow flags
- `acc`  out  8  live accumulator value

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`, latch `op_r`, `data_r`, `cnt_r`=`cmd_rep`, clear sticky V, and go to EXEC.
- AU drive (combinational from registers):
  - `au_x`=`acc`, `au_y`=`data_r`.
  - `{au_s1,au_s0,au_cin}`=`op_r` in EXEC.
  - In IDLE/DONE: selects=000 and `au_y`=0.
- EXEC, every cycle:
  - `acc`<=`au_f`, C<=`au_cout`.
  - V_sticky |= step_v.
  - If `cnt_r`==0, go to DONE; else `cnt_r`<=`cnt_r`−1.
- step_v, with a=acc, r=au_f:
  - Ops 2, 3: b=`data_r`, V=(a7==b7)&&(r7!=a7).
  - Op 1: same rule with b=0x01.
  - Ops 4, 5: b=`data_r`, V=(a7!=b7)&&(r7!=a7).
  - Op 6: same rule with b=0x01.
  - Ops 0, 7: V=0.
- DONE:
  - `rsp_valid`=1.
  - Z=(`acc`==0), N=`acc[7]`, C=last-step carry, V=sticky.
  - On `rsp_valid&&rsp_ready`, go to IDLE.
  - `rsp_*` held stable while `rsp_ready`=0.
- Accumulator persists across commands; there is no implicit clear. Op 7 loads it.

## Timing
- Reset values:
  - State IDLE; `acc`=0, C=Z=N=V=0, `cnt_r`=0.
  - `rsp_valid`=0, `cmd_ready`=0 during the reset cycle and 1 in the first cycle after.
  - `au_x`=0, `au_y`=0, selects=000.
- Latency: command accepted at edge E. EXEC occupies the `cmd_rep+1` cycles after E. `rsp_valid` rises `cmd_rep+2` cycles after E.
- `cmd_ready`=0 throughout EXEC and DONE. Minimum command spacing is `cmd_rep`+3 cycles with `rsp_ready` tied high.
- Response handshake at edge H: `rsp_valid` is 0 and `cmd_ready` is 1 in the cycle after H.
- Repeat wrap: `cmd_rep`=2^CNT_W−1 gives 2^CNT_W steps. The counter never wraps below 0.
- Arithmetic is modulo 256. Overflow is signalled only via C/V; `acc` wraps silently.
- `rst` mid-EXEC or DONE aborts the command. No response is produced, and all registers take their reset values on that edge.
- `cmd_valid` during EXEC/DONE is ignored, with no latching. `rsp_ready` outside DONE is ignored.

## Structure
- Shared `au_pkg`:
  - Opcode constants OP_XFER_X..OP_XFER_Y (0..7).
  - State encoding (IDLE=0, EXEC=1, DONE=2).
  - Opcode-to-select mapping: s1=op[2], s0=op[1], cin=op[0].
- One combinational sub-module, `au_flag_calc`: inputs op, a, b, r; output step_v. Z/N are derived from a value.
- The AU itself is instantiated by the parent, not inside this block.

## Test plan
The bench uses a behavioural AU model whose `cout` is the 8-bit adder carry-out, and 0 for ops 0 and 7.
- After reset, op7 data 0x0A rep0 → `rsp_valid` 2 cycles after accept; `rsp_acc`=0x0A, C=Z=N=V=0.
- acc=0x0A, op2 data 0x08 rep0 → `rsp_acc`=0x12, C=0, V=0; op4 data 0x12 → `rsp_acc`=0x00, Z=1, C=1.
- acc=0x05, op2 data 0x07 rep3 → `rsp_acc`=0x21; `rsp_valid` exactly 5 cycles after accept; `cmd_ready`=0 until the response handshake.
- acc=0x7F, op1 rep0 → `rsp_acc`=0x80, N=1, V=1, C=0; then op6 twice from 0x00 → 0xFF, N=1, C=0, then 0xFE.
- `rsp_ready` low for 3 cycles in DONE → `rsp_*` stable and new `cmd_valid` ignored; after the handshake, `cmd_ready`=1 next cycle.
- `rst` asserted in the 2nd EXEC cycle of op2 rep5 → next cycle `acc`=0, state IDLE, `rsp_valid` never asserted.

Source files
------------

// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared opcodes, sequencer states and select mapping for the AU
package au_pkg;

    localparam logic [2:0] OP_XFER_X = 3'd0;
    localparam logic [2:0] OP_INC    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_ADDC   = 3'd3;
    localparam logic [2:0] OP_SUB    = 3'd4;
    localparam logic [2:0] OP_SUBB   = 3'd5;
    localparam logic [2:0] OP_DEC    = 3'd6;
    localparam logic [2:0] OP_XFER_Y = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {s1, s0, cin}; the opcode bits map straight onto the AU selects.
    function automatic logic [2:0] op_to_sel(input logic [2:0] op);
        return {op[2], op[1], op[0]};
    endfunction

    function automatic logic is_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

endpackage

// File: rtl/au_flag_calc.sv
// rtl/au_flag_calc.sv - per-step signed overflow for one AU operation
module au_flag_calc
    import au_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] r,
    output logic       step_v
);

    // Only the sign bits take part in the overflow rule.
    logic unused_bits;
    assign unused_bits = ^{a[6:0], b[6:0], r[6:0]};

    always_comb begin
        step_v = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: step_v = (a[7] == b[7]) && (r[7] != a[7]);
            OP_INC:          step_v = (a[7] == 1'b0) && (r[7] != a[7]);
            OP_SUB, OP_SUBB: step_v = (a[7] != b[7]) && (r[7] != a[7]);
            OP_DEC:          step_v = (a[7] != 1'b0) && (r[7] != a[7]);
            default:         step_v = 1'b0;
        endcase
    end

endmodule

// File: rtl/au_acc_seq.sv
// rtl/au_acc_seq.sv - command-driven accumulator sequencer around an external 8-bit AU
module au_acc_seq
    import au_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [7:0]       au_x,
    output logic [7:0]       au_y,
    output logic             au_s1,
    output logic             au_s0,
    output logic             au_cin,
    input  logic [7:0]       au_f,
    input  logic             au_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_acc,
    output logic             rsp_c,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_v,
    output logic [7:0]       acc
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [2:0]       op_r;
    logic [7:0]       data_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       acc_r;
    logic             c_r;
    logic             z_r;
    logic             n_r;
    logic             v_r;
    logic             rsp_valid_r;
    logic             step_v;
    logic             in_exec;

    assign in_exec = (state == ST_EXEC);

    assign au_x = acc_r;
    assign au_y = in_exec ? data_r : 8'h00;
    assign {au_s1, au_s0, au_cin} = in_exec ? op_to_sel(op_r) : 3'b000;

    au_flag_calc u_flag_calc (
        .op     (op_r),
        .a      (acc_r),
        .b      (data_r),
        .r      (au_f),
        .step_v (step_v)
    );

    // Gated by rst so the channel reads not-ready during the reset cycle itself.
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_r;
    assign rsp_acc   = acc_r;
    assign rsp_c     = c_r;
    assign rsp_z     = z_r;
    assign rsp_n     = n_r;
    assign rsp_v     = v_r;
    assign acc       = acc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_r        <= OP_XFER_X;
            data_r      <= 8'h00;
            cnt_r       <= '0;
            acc_r       <= 8'h00;
            c_r         <= 1'b0;
            z_r         <= 1'b0;
            n_r         <= 1'b0;
            v_r         <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        cnt_r  <= cmd_rep;
                        v_r    <= 1'b0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_r <= au_f;
                    c_r   <= au_cout;
                    v_r   <= v_r | step_v;
                    // Z/N are captured from the final result so they stay stable in DONE.
                    if (cnt_r == '0) begin
                        z_r         <= is_zero(au_f);
                        n_r         <= au_f[7];
                        rsp_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_au_acc_seq.sv
// tb/tb_au_acc_seq.sv - directed checks of au_acc_seq against a behavioural AU
module tb_au_acc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_rep = 4'd0;
    logic [7:0] au_x;
    logic [7:0] au_y;
    logic       au_s1;
    logic       au_s0;
    logic       au_cin;
    logic [7:0] au_f;
    logic       au_cout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_acc;
    logic       rsp_c;
    logic       rsp_z;
    logic       rsp_n;
    logic       rsp_v;
    logic [7:0] acc;

    int checks = 0;
    int failures = 0;

    au_acc_seq #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rep   (cmd_rep),
        .au_x      (au_x),
        .au_y      (au_y),
        .au_s1     (au_s1),
        .au_s0     (au_s0),
        .au_cin    (au_cin),
        .au_f      (au_f),
        .au_cout   (au_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_acc   (rsp_acc),
        .rsp_c     (rsp_c),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .rsp_v     (rsp_v),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    // Behavioural AU: cout is the 8-bit adder carry, zero for the transfers.
    logic [8:0] sum;
    always_comb begin
        sum = 9'd0;
        case ({au_s1, au_s0, au_cin})
            3'd0: sum = {1'b0, au_x};
            3'd1: sum = {1'b0, au_x} + 9'd1;
            3'd2: sum = {1'b0, au_x} + {1'b0, au_y};
            3'd3: sum = {1'b0, au_x} + {1'b0, au_y} + 9'd1;
            3'd4: sum = {1'b0, au_x} + {1'b0, ~au_y} + 9'd1;
            3'd5: sum = {1'b0, au_x} + {1'b0, ~au_y};
            3'd6: sum = {1'b0, au_x} + 9'h0FF;
            default: sum = {1'b0, au_y};
        endcase
        au_f    = sum[7:0];
        au_cout = sum[8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] rep;
        logic [7:0] acc;
        logic [3:0] cznv;
    } vec_t;

    vec_t vecs[14];

    // Issue one command from a negedge, wait for the response, handshake it.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input logic [3:0] rep,
                           output int lat, output logic [7:0] racc, output logic [3:0] cznv);
        logic busy_ok;
        cmd_op    = op;
        cmd_data  = data;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 64 && lat == 0; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (cmd_ready) busy_ok = 1'b0;
            if (rsp_valid) lat = k;
        end
        check("cmd_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
        racc = rsp_acc;
        cznv = {rsp_c, rsp_z, rsp_n, rsp_v};
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after_handshake", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] racc;
        logic [3:0] cznv;
        logic       ok;

        vecs[0]  = '{3'd7, 8'h0A, 4'd0,  8'h0A, 4'b0000};
        vecs[1]  = '{3'd2, 8'h08, 4'd0,  8'h12, 4'b0000};
        vecs[2]  = '{3'd4, 8'h12, 4'd0,  8'h00, 4'b1100};
        vecs[3]  = '{3'd7, 8'h05, 4'd0,  8'h05, 4'b0000};
        vecs[4]  = '{3'd2, 8'h07, 4'd3,  8'h21, 4'b0000};
        vecs[5]  = '{3'd7, 8'h7F, 4'd0,  8'h7F, 4'b0000};
        vecs[6]  = '{3'd1, 8'h00, 4'd0,  8'h80, 4'b0011};
        vecs[7]  = '{3'd7, 8'h00, 4'd0,  8'h00, 4'b0100};
        vecs[8]  = '{3'd6, 8'h00, 4'd0,  8'hFF, 4'b0010};
        vecs[9]  = '{3'd6, 8'h00, 4'd0,  8'hFE, 4'b1010};
        vecs[10] = '{3'd7, 8'h80, 4'd0,  8'h80, 4'b0010};
        vecs[11] = '{3'd5, 8'h01, 4'd0,  8'h7E, 4'b1001};
        vecs[12] = '{3'd3, 8'h10, 4'd15, 8'h8E, 4'b0011};
        vecs[13] = '{3'd0, 8'h55, 4'd2,  8'h8E, 4'b0010};

        repeat (2) @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("reset_acc", {24'd0, acc}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_au_drive", {21'd0, au_x, au_y, au_s1, au_s0, au_cin}, 32'd0);
        check("reset_flags", {28'd0, rsp_c, rsp_z, rsp_n, rsp_v}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].rep, lat, racc, cznv);
            check($sformatf("vec%0d_latency", i), lat, 32'(vecs[i].rep) + 32'd2);
            check($sformatf("vec%0d_acc", i), {24'd0, racc}, {24'd0, vecs[i].acc});
            check($sformatf("vec%0d_cznv", i), {28'd0, cznv}, {28'd0, vecs[i].cznv});
        end

        // Back-pressured response: held stable, competing command ignored.
        rsp_ready = 1'b0;
        cmd_op    = 3'd7;
        cmd_data  = 8'h33;
        cmd_rep   = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_data = 8'h99;
        lat = 0;
        for (int k = 0; k < 20 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = 1;
        end
        check("bp_rsp_valid_seen", lat, 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (!rsp_valid || rsp_acc !== 8'h33 || cmd_ready) ok = 1'b0;
            @(negedge clk);
        end
        check("bp_rsp_stable", {31'd0, ok}, 32'd1);
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("bp_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
        check("bp_cmd_not_latched", {24'd0, acc}, 32'h33);

        // Reset during the second EXEC cycle of a long add.
        cmd_op    = 3'd2;
        cmd_data  = 8'h01;
        cmd_rep   = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_acc_before", {24'd0, acc}, 32'h34);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_acc_cleared", {24'd0, acc}, 32'd0);
        check("abort_au_selects", {29'd0, au_s1, au_s0, au_cin}, 32'd0);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready || acc !== 8'h00) ok = 1'b0;
        end
        check("abort_no_response_idle", {31'd0, ok}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
